// File: rtl/ie_pkg.sv
// Shared constants and the buffer-entry type for the integer-execute operand path.
package ie_pkg;

  localparam int IE_WIDTH = 32;
  localparam int IE_N_IN  = 4;
  localparam int IE_SEL_W = 2;

  typedef struct packed {
    logic [IE_WIDTH-1:0] data;
    logic                sel_err;
  } ie_entry_t;

endpackage

// File: rtl/ie_lane_sel.sv
// Combinational lane picker: selects one WIDTH-bit lane and flags selectors past the last lane.
module ie_lane_sel import ie_pkg::*; #(
  parameter int WIDTH = IE_WIDTH,
  parameter int N_IN  = IE_N_IN,
  parameter int SEL_W = IE_SEL_W
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      data,
  output logic                  sel_err
);

  // Compare at 32 bits so a wide selector never aliases onto a real lane.
  always_comb begin
    data    = '0;
    sel_err = (32'(sel) >= N_IN);
    for (int k = 0; k < N_IN; k++) begin
      if (32'(sel) == k) begin
        data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/ie_operand_mux.sv
// Operand lane mux feeding a two-entry skid buffer (head + skid) with a sticky selector-error flag.
module ie_operand_mux import ie_pkg::*; #(
  parameter int WIDTH = IE_WIDTH,
  parameter int N_IN  = IE_N_IN,
  parameter int SEL_W = IE_SEL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err_sticky,
  input  logic                  err_clear
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sel_err;
  } entry_t;

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  entry_t           cap_p0;
  entry_t           main_p1;
  entry_t           skid_p1;
  logic             main_vld_p1;
  logic             skid_vld_p1;
  logic             main_vld_nxt;
  logic             skid_vld_nxt;
  logic             accept;
  logic             pop;
  logic             load_main_cap;
  logic             load_main_skid;
  logic             load_skid;

  // Stage p0: lane selection on the offered operand
  ie_lane_sel #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_lane_sel (
    .in_data (in_data),
    .sel     (sel),
    .data    (sel_data),
    .sel_err (sel_err)
  );

  assign cap_p0 = '{data: sel_data, sel_err: sel_err};

  assign in_ready = ~skid_vld_p1;
  assign accept   = in_valid & in_ready;
  assign pop      = main_vld_p1 & out_ready;

  always_comb begin
    main_vld_nxt   = main_vld_p1;
    skid_vld_nxt   = skid_vld_p1;
    load_main_cap  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_vld_nxt = 1'b0;
      skid_vld_nxt = 1'b0;
    end else if (!skid_vld_p1) begin
      if (accept && (!main_vld_p1 || pop)) begin
        main_vld_nxt  = 1'b1;
        load_main_cap = 1'b1;
      end else if (accept) begin
        skid_vld_nxt = 1'b1;
        load_skid    = 1'b1;
      end else if (pop) begin
        main_vld_nxt = 1'b0;
      end
    end else if (pop) begin
      skid_vld_nxt   = 1'b0;
      load_main_skid = 1'b1;
    end
  end

  // Stage p1: head and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else begin
      main_vld_p1 <= main_vld_nxt;
      skid_vld_p1 <= skid_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (load_main_cap) begin
      main_p1 <= cap_p0;
    end else if (load_main_skid) begin
      main_p1 <= skid_p1;
    end
    if (load_skid) begin
      skid_p1 <= cap_p0;
    end
  end

  // A set on the same edge as a clear must win so no error is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (accept && cap_p0.sel_err) begin
      err_sticky <= 1'b1;
    end else if (err_clear) begin
      err_sticky <= 1'b0;
    end
  end

  // Data registers carry no reset, so outputs are gated by the head valid bit.
  assign out_valid   = main_vld_p1;
  assign out_data    = main_vld_p1 ? main_p1.data : '0;
  assign out_sel_err = main_vld_p1 & main_p1.sel_err;

endmodule

// File: tb/tb_ie_operand_mux.sv
// Bench for ie_operand_mux: a 4-lane and a 3-lane instance driven in lockstep, each against its own queue model.
module tb_ie_operand_mux;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } ent_t;

  typedef struct {
    logic [127:0] lanes;
    logic [1:0]   sel;
    bit           v;
    bit           ordy;
    bit           fl;
    bit           clr;
    bit           exp_rdy;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] d_lanes = '0;
  logic [1:0]   d_sel = '0;
  logic         d_valid = 1'b0;
  logic         d_oready = 1'b0;
  logic         d_flush = 1'b0;
  logic         d_clr = 1'b0;

  logic         a_in_ready, a_out_sel_err, a_out_valid, a_err_sticky;
  logic [31:0]  a_out_data;
  logic         b_in_ready, b_out_sel_err, b_out_valid, b_err_sticky;
  logic [31:0]  b_out_data;

  int checks = 0;
  int errors = 0;
  ent_t qa[$];
  ent_t qb[$];
  bit erra = 1'b0;
  bit errb = 1'b0;
  vec_t tbl[10];

  always #5 clk = ~clk;

  ie_operand_mux #(.WIDTH(32), .N_IN(4), .SEL_W(2)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (d_lanes),
    .sel         (d_sel),
    .in_valid    (d_valid),
    .in_ready    (a_in_ready),
    .flush       (d_flush),
    .out_data    (a_out_data),
    .out_sel_err (a_out_sel_err),
    .out_valid   (a_out_valid),
    .out_ready   (d_oready),
    .err_sticky  (a_err_sticky),
    .err_clear   (d_clr)
  );

  ie_operand_mux #(.WIDTH(32), .N_IN(3), .SEL_W(2)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (d_lanes[95:0]),
    .sel         (d_sel),
    .in_valid    (d_valid),
    .in_ready    (b_in_ready),
    .flush       (d_flush),
    .out_data    (b_out_data),
    .out_sel_err (b_out_sel_err),
    .out_valid   (b_out_valid),
    .out_ready   (d_oready),
    .err_sticky  (b_err_sticky),
    .err_clear   (d_clr)
  );

  function automatic ent_t sel_model(input logic [127:0] lanes, input int s, input int n);
    ent_t r;
    if (s < n) begin
      r.d = lanes[s*32 +: 32];
      r.e = 1'b0;
    end else begin
      r.d = '0;
      r.e = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("a_in_ready", 32'(a_in_ready), 32'(qa.size() < 2));
    chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() > 0));
    chk("a_err_sticky", 32'(a_err_sticky), 32'(erra));
    if (qa.size() > 0) begin
      chk("a_out_data", a_out_data, qa[0].d);
      chk("a_out_sel_err", 32'(a_out_sel_err), 32'(qa[0].e));
    end
    chk("b_in_ready", 32'(b_in_ready), 32'(qb.size() < 2));
    chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() > 0));
    chk("b_err_sticky", 32'(b_err_sticky), 32'(errb));
    if (qb.size() > 0) begin
      chk("b_out_data", b_out_data, qb[0].d);
      chk("b_out_sel_err", 32'(b_out_sel_err), 32'(qb[0].e));
    end
  endtask

  task automatic drive(input logic [127:0] lanes, input int s, input bit v, input bit ordy,
                       input bit fl, input bit clr);
    d_lanes  = lanes;
    d_sel    = 2'(s);
    d_valid  = v;
    d_oready = ordy;
    d_flush  = fl;
    d_clr    = clr;
  endtask

  // Check, then advance one edge and update both models with the pre-edge handshake.
  task automatic cyc();
    bit acc_a, acc_b, pop_a, pop_b;
    ent_t ea, eb;
    check_outputs();
    acc_a = d_valid && (qa.size() < 2);
    acc_b = d_valid && (qb.size() < 2);
    pop_a = d_oready && (qa.size() > 0);
    pop_b = d_oready && (qb.size() > 0);
    ea = sel_model(d_lanes, int'(d_sel), 4);
    eb = sel_model(d_lanes, int'(d_sel), 3);
    @(posedge clk);
    if (d_flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pop_a) void'(qa.pop_front());
      if (acc_a) qa.push_back(ea);
      if (pop_b) void'(qb.pop_front());
      if (acc_b) qb.push_back(eb);
    end
    if (acc_a && ea.e) erra = 1'b1;
    else if (d_clr) erra = 1'b0;
    if (acc_b && eb.e) errb = 1'b1;
    else if (d_clr) errb = 1'b0;
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_a_out_data", a_out_data, 32'd0);
    chk("rst_a_out_sel_err", 32'(a_out_sel_err), 32'd0);
    chk("rst_a_err_sticky", 32'(a_err_sticky), 32'd0);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    chk("rst_b_out_data", b_out_data, 32'd0);
    chk("rst_b_err_sticky", 32'(b_err_sticky), 32'd0);
  endtask

  localparam logic [127:0] L0 = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] L1 = {32'hdead_0004, 32'hdead_0003, 32'hdead_0002, 32'hdead_0001};
  localparam logic [127:0] L2 = {32'hbeef_0d04, 32'hbeef_0c03, 32'hbeef_0b02, 32'hbeef_0a01};

  initial begin
    //            lanes sel v  ordy fl clr exp_rdy
    tbl[0] = '{L0, 2'd2, 1, 1, 0, 0, 1};
    tbl[1] = '{L0, 2'd0, 1, 1, 0, 0, 1};
    tbl[2] = '{L0, 2'd3, 1, 0, 0, 0, 0};
    tbl[3] = '{L0, 2'd1, 1, 0, 0, 0, 0};
    tbl[4] = '{L0, 2'd1, 0, 1, 0, 0, 1};
    tbl[5] = '{L1, 2'd1, 1, 1, 0, 0, 1};
    tbl[6] = '{L1, 2'd0, 0, 1, 0, 0, 1};
    tbl[7] = '{L1, 2'd3, 1, 0, 0, 1, 1};
    tbl[8] = '{L1, 2'd0, 0, 0, 0, 1, 1};
    tbl[9] = '{L1, 2'd0, 0, 1, 0, 0, 1};

    drive(L0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    #12;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].lanes, int'(tbl[i].sel), tbl[i].v, tbl[i].ordy, tbl[i].fl, tbl[i].clr);
      cyc();
      chk("tbl_a_in_ready", 32'(a_in_ready), 32'(tbl[i].exp_rdy));
    end
    check_outputs();

    // Backpressure: two accepts stall the input, then drain in order.
    drive(L2, 0, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    drive(L2, 1, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    chk("bp_a_in_ready_low", 32'(a_in_ready), 32'd0);
    drive(L2, 2, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    drive(L2, 2, 1'b0, 1'b1, 1'b0, 1'b0); cyc();
    chk("bp_a_first", a_out_data, 32'hbeef_0b02);
    cyc(); cyc();

    // Flush with both entries full and a fresh offer.
    drive(L1, 2, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    drive(L1, 3, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    drive(L0, 1, 1'b1, 1'b1, 1'b1, 1'b0); cyc();
    chk("fl_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("fl_a_in_ready", 32'(a_in_ready), 32'd1);
    chk("fl_b_err_kept", 32'(b_err_sticky), 32'd1);
    drive(L0, 0, 1'b0, 1'b1, 1'b0, 1'b1); cyc(); cyc();

    // Asynchronous reset between edges with two entries held.
    drive(L2, 3, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    drive(L2, 1, 1'b1, 1'b0, 1'b0, 1'b0); cyc();
    check_outputs();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    qa.delete();
    qb.delete();
    erra = 1'b0;
    errb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(L0, 3, 1'b1, 1'b1, 1'b0, 1'b0); cyc();
    chk("post_rst_a_data", a_out_data, 32'h44);
    drive(L0, 0, 1'b0, 1'b1, 1'b0, 1'b0); cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ie_operand_mux.md
IE_OPERAND_MUX -- requirements
Module: ie_operand_mux

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 32, as the data width of every input lane and of the output.
REQ-002 The block SHALL expose parameter N_IN, default 4, as the number of selectable input lanes; legal range is 2..16.
REQ-003 The block SHALL expose parameter SEL_W, default 2, as the selector width; it SHALL be at least clog2(N_IN).
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-006 in_data  in  N_IN*WIDTH  flattened lanes; lane k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  in  SEL_W  lane index, sampled with in_data on acceptance.
REQ-008 in_valid  in  1  upstream offers in_data/sel this cycle.
REQ-009 in_ready  out  1  block can accept this cycle.
REQ-010 flush  in  1  synchronous pipeline flush (branch mispredict / trap).
REQ-011 out_data  out  WIDTH  selected operand of the head entry.
REQ-012 out_sel_err  out  1  head entry was captured with an out-of-range sel.
REQ-013 out_valid  out  1  head entry present.
REQ-014 out_ready  in  1  downstream consumes the head entry this cycle.
REQ-015 err_sticky  out  1  latched: any out-of-range sel accepted since the last clear.
REQ-016 err_clear  in  1  clears err_sticky.

Function
REQ-017 Accept occurs when in_valid and in_ready are both high on a rising edge; pop occurs when out_valid and out_ready are both high.
REQ-018 On accept, the captured data SHALL be lane sel when sel < N_IN, else all zeros with the entry's sel_err bit set.
REQ-019 Storage SHALL be a two-entry skid buffer: a main (head) register driving the outputs and one skid register.
REQ-020 in_ready SHALL equal NOT skid_valid; it SHALL NOT depend combinationally on in_valid or out_ready.
REQ-021 Latency SHALL be one cycle: data accepted at edge N into an empty buffer appears at out_data with out_valid=1 after edge N.
REQ-022 Transitions with skid empty: accept with main empty or pop loads main; accept with main valid and no pop loads skid; pop without accept empties main.
REQ-023 Transitions with skid valid (no accept possible): pop moves skid into main and empties skid; no pop holds both.
REQ-024 Entries SHALL leave in acceptance order; no entry is dropped or duplicated absent flush.
REQ-025 out_data and out_sel_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 flush SHALL clear main and skid valid bits at the next edge, overriding simultaneous accept and pop; the offered input is discarded.
REQ-027 err_sticky SHALL set on any accept with sel >= N_IN; on the same edge as err_clear, set wins.
REQ-028 flush SHALL NOT clear err_sticky.

Reset
REQ-029 While rst_n=0: out_valid=0, skid empty, in_ready=1, out_data=0, out_sel_err=0, err_sticky=0.
REQ-030 Reset asserted mid-transfer SHALL discard all held entries immediately, without waiting for a clock edge.
REQ-031 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-032 Default WIDTH, N_IN and SEL_W SHALL be constants in the shared ie_pkg package, alongside a struct {data, sel_err} for a buffer entry.
REQ-033 Lane selection with the out-of-range check SHALL be one combinational sub-module, ie_lane_sel; the skid control stays in ie_operand_mux.

Verification
REQ-034 Stream: lanes 0x11,0x22,0x33,0x44, sel=2, in_valid=1, out_ready=1 -> out_data=0x33 one cycle later, in_ready held 1.
REQ-035 Backpressure: out_ready=0, accept A then B -> in_ready=0 after the second edge; raise out_ready -> A, then B, in order, no loss.
REQ-036 N_IN=3, SEL_W=2, sel=3 accepted -> out_data=0, out_sel_err=1, err_sticky=1; err_clear asserted together with another sel=3 accept -> err_sticky stays 1.
REQ-037 Both entries full, flush=1 with in_valid=1 -> after the edge out_valid=0, in_ready=1, offered data never appears.
REQ-038 rst_n pulled low between edges with two entries held -> out_valid=0 and in_ready=1 before the next edge.
